// File: rtl/cdc_pkg.sv
// Shared definitions for the destination-side CDC handshake controller:
// FSM state encodings and default widths.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_ACCEPT  = 2'b01,
        WAIT_RELEASE = 2'b10
    } cdc_state_e;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/en_sync_chain.sv
// Single-bit flop chain that brings the asynchronous source request into the
// destination clock domain. Output is the last stage.
module en_sync_chain #(
    parameter int NUM_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_ctrl.sv
// Destination-domain controller for a 4-phase REQ/ACK multi-bit transfer:
// synchronizes BUS_EN, captures the quasi-static bus once, hands it out with VALID/READY, returns ACK.
module cdc_handshake_ctrl
    import cdc_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 SYNC_ACK,
    output logic                 PROTO_ERR,
    output logic [CNT_WIDTH-1:0] XFER_CNT,
    output cdc_state_e           DBG_STATE
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Consumer handshake: a word transfers on every cycle where DATA_VALID and
    // DATA_READY are both high; DATA_VALID never drops without that acceptance
    // and SYNC_BUS is stable while DATA_VALID is high.

    logic                 w_en_s;
    logic                 w_rise;
    logic                 w_accept;

    logic                 r_en_prev;
    cdc_state_e           r_state;
    logic [BUS_WIDTH-1:0] r_sync_bus;
    logic                 r_valid;
    logic                 r_ack;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_cnt;

    cdc_state_e           w_state_nxt;
    logic [BUS_WIDTH-1:0] w_bus_nxt;
    logic                 w_valid_nxt;
    logic                 w_ack_nxt;
    logic                 w_err_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    en_sync_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_async (BUS_EN),
        .o_sync  (w_en_s)
    );

    assign w_rise   = w_en_s & ~r_en_prev;
    assign w_accept = r_valid & DATA_READY;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_en_prev <= 1'b0;
        end else begin
            r_en_prev <= w_en_s;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_sync_bus <= '0;
            r_valid    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_bus <= w_bus_nxt;
            r_valid    <= w_valid_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_nxt   = r_sync_bus;
        w_valid_nxt = r_valid;
        w_ack_nxt   = r_ack;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                // The bus is sampled directly: the source keeps it stable while BUS_EN is high.
                if (w_rise) begin
                    w_bus_nxt   = UNSYNC_BUS;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (!w_en_s) begin
                    w_err_nxt = 1'b1;
                end
                if (w_accept) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!w_en_s) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                // Illegal encoding: recover exactly as from reset.
                w_state_nxt = IDLE;
                w_bus_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_ack_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign SYNC_BUS   = r_sync_bus;
    assign DATA_VALID = r_valid;
    assign SYNC_ACK   = r_ack;
    assign PROTO_ERR  = r_err;
    assign XFER_CNT   = r_cnt;
    assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_cdc_handshake_ctrl.sv
// Self-checking bench for cdc_handshake_ctrl: latency sequence, vector table,
// mid-transfer reset and a full counter wrap, with a data scoreboard.
module tb_cdc_handshake_ctrl;
    import cdc_pkg::*;

    localparam int NS = 2;
    localparam int BW = 8;
    localparam int CW = 8;

    logic          CLK;
    logic          RST;
    logic [BW-1:0] UNSYNC_BUS;
    logic          BUS_EN;
    logic [BW-1:0] SYNC_BUS;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic          SYNC_ACK;
    logic          PROTO_ERR;
    logic [CW-1:0] XFER_CNT;
    cdc_state_e    DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] exp_q[$];

    typedef struct {
        logic [BW-1:0] data;
        int            rwait;
        bit            drop;
        logic          exp_err;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    cdc_handshake_ctrl #(
        .NUM_STAGES (NS),
        .BUS_WIDTH  (BW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .UNSYNC_BUS (UNSYNC_BUS),
        .BUS_EN     (BUS_EN),
        .SYNC_BUS   (SYNC_BUS),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .SYNC_ACK   (SYNC_ACK),
        .PROTO_ERR  (PROTO_ERR),
        .XFER_CNT   (XFER_CNT),
        .DBG_STATE  (DBG_STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        return (sel == 0) ? DATA_VALID : SYNC_ACK;
    endfunction

    // Polls on the falling edge so the caller resumes away from the active edge.
    task automatic wait_for(input int sel, input logic lvl, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge CLK);
            if (sig_of(sel) === lvl) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic reset_dut();
        RST        = 1'b0;
        BUS_EN     = 1'b0;
        DATA_READY = 1'b0;
        UNSYNC_BUS = '0;
        tick();
        tick();
        exp_q.delete();
        RST = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, DATA_VALID}, 32'd0);
        chk({tag, "_ack"},   {31'd0, SYNC_ACK},   32'd0);
        chk({tag, "_err"},   {31'd0, PROTO_ERR},  32'd0);
        chk({tag, "_cnt"},   {24'd0, XFER_CNT},   32'd0);
        chk({tag, "_bus"},   {24'd0, SYNC_BUS},   32'd0);
        chk({tag, "_state"}, {30'd0, DBG_STATE},  {30'd0, IDLE});
    endtask

    task automatic xfer(input logic [BW-1:0] d, input int rwait, input bit drop);
        UNSYNC_BUS = d;
        BUS_EN     = 1'b1;
        DATA_READY = (rwait == 0);
        exp_q.push_back(d);
        wait_for(0, 1'b1, "valid_rise");
        if (rwait > 0) begin
            if (drop) BUS_EN = 1'b0;
            for (int i = 0; i < rwait; i++) begin
                chk("hold_bus",   {24'd0, SYNC_BUS},   {24'd0, d});
                chk("hold_valid", {31'd0, DATA_VALID}, 32'd1);
                chk("hold_ack",   {31'd0, SYNC_ACK},   32'd0);
                tick();
            end
            DATA_READY = 1'b1;
        end
        wait_for(1, 1'b1, "ack_rise");
        DATA_READY = 1'b0;
        BUS_EN     = 1'b0;
        wait_for(1, 1'b0, "ack_fall");
        chk("state_idle", {30'd0, DBG_STATE}, {30'd0, IDLE});
    endtask

    // Scoreboard: every accepted word must match the oldest driven word.
    always @(negedge CLK) begin
        if (RST && DATA_VALID && DATA_READY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected none", SYNC_BUS);
            end else begin
                chk("sb_data", {24'd0, SYNC_BUS}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [CW-1:0] cnt_model;
        logic [BW-1:0] d;

        vecs[0] = '{data: 8'h3C, rwait: 0, drop: 1'b0, exp_err: 1'b0, exp_cnt: 8'd2};
        vecs[1] = '{data: 8'h5A, rwait: 5, drop: 1'b0, exp_err: 1'b0, exp_cnt: 8'd3};
        vecs[2] = '{data: 8'hC3, rwait: 2, drop: 1'b0, exp_err: 1'b0, exp_cnt: 8'd4};
        vecs[3] = '{data: 8'hF0, rwait: 4, drop: 1'b1, exp_err: 1'b1, exp_cnt: 8'd5};
        vecs[4] = '{data: 8'h0F, rwait: 1, drop: 1'b0, exp_err: 1'b1, exp_cnt: 8'd6};
        vecs[5] = '{data: 8'h81, rwait: 3, drop: 1'b0, exp_err: 1'b1, exp_cnt: 8'd7};

        reset_dut();
        chk_reset_state("rst0");

        // Exact latency: BUS_EN set before edge k, VALID at k+2, accept at k+3.
        UNSYNC_BUS = 8'hA5;
        BUS_EN     = 1'b1;
        DATA_READY = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        chk("lat_k_valid", {31'd0, DATA_VALID}, 32'd0);
        tick();
        chk("lat_k1_valid", {31'd0, DATA_VALID}, 32'd0);
        tick();
        chk("lat_k2_valid", {31'd0, DATA_VALID}, 32'd1);
        chk("lat_k2_bus", {24'd0, SYNC_BUS}, 32'hA5);
        chk("lat_k2_ack", {31'd0, SYNC_ACK}, 32'd0);
        tick();
        chk("lat_k3_valid", {31'd0, DATA_VALID}, 32'd0);
        chk("lat_k3_ack", {31'd0, SYNC_ACK}, 32'd1);
        chk("lat_k3_cnt", {24'd0, XFER_CNT}, 32'd1);
        chk("lat_k3_state", {30'd0, DBG_STATE}, {30'd0, WAIT_RELEASE});
        BUS_EN     = 1'b0;
        DATA_READY = 1'b0;
        tick();
        chk("rel_1_ack", {31'd0, SYNC_ACK}, 32'd1);
        tick();
        chk("rel_2_ack", {31'd0, SYNC_ACK}, 32'd1);
        tick();
        chk("rel_3_ack", {31'd0, SYNC_ACK}, 32'd0);
        chk("rel_3_state", {30'd0, DBG_STATE}, {30'd0, IDLE});

        for (int v = 0; v < 6; v++) begin
            xfer(vecs[v].data, vecs[v].rwait, vecs[v].drop);
            chk("vec_err", {31'd0, PROTO_ERR}, {31'd0, vecs[v].exp_err});
            chk("vec_cnt", {24'd0, XFER_CNT}, {24'd0, vecs[v].exp_cnt});
        end
        chk("vec_sb_empty", exp_q.size(), 32'd0);

        // Reset while a word is waiting for the consumer.
        UNSYNC_BUS = 8'h77;
        BUS_EN     = 1'b1;
        DATA_READY = 1'b0;
        wait_for(0, 1'b1, "mid_valid");
        chk("mid_state", {30'd0, DBG_STATE}, {30'd0, WAIT_ACCEPT});
        RST    = 1'b0;
        BUS_EN = 1'b0;
        tick();
        chk_reset_state("mid_rst");
        RST = 1'b1;
        tick();
        chk_reset_state("mid_post");

        // Full counter wrap with random data and consumer stalls.
        cnt_model = '0;
        for (int i = 0; i < 256; i++) begin
            d = BW'($urandom_range(0, 255));
            xfer(d, $urandom_range(0, 2), 1'b0);
            cnt_model = cnt_model + 8'd1;
            chk("wrap_cnt", {24'd0, XFER_CNT}, {24'd0, cnt_model});
        end
        chk("wrap_cnt_zero", {24'd0, XFER_CNT}, 32'd0);
        chk("wrap_err", {31'd0, PROTO_ERR}, 32'd0);
        chk("wrap_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
